// File: rtl/count_capture_pkg.sv
// Shared types and default sizing for the count_capture time-stamp unit.
package count_capture_pkg;

    localparam int unsigned CC_WIDTH = 21;
    localparam int unsigned CC_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } cc_state_e;

    typedef struct packed {
        logic [CC_WIDTH-1:0] stamp;
        logic [CC_WIDTH-1:0] period;
    } cc_entry_t;

endpackage

// File: rtl/cc_fifo.sv
// Synchronous FIFO whose head is always entry 0 of a flop array, so the
// head output is registered and reads as zero after reset.
module cc_fifo import count_capture_pkg::*; #(
    parameter int unsigned DW    = 2 * CC_WIDTH,
    parameter int unsigned DEPTH = CC_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [LW-1:0] count_q;
    logic          do_pop;
    logic          do_push;
    logic [AW-1:0] wr_idx;

    assign empty   = (count_q == '0);
    assign full    = (count_q == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // When popping, the shift frees one slot below the current fill point.
    assign wr_idx  = do_pop ? AW'(count_q - LW'(1)) : AW'(count_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (do_push) begin
                mem[wr_idx] <= din;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + LW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - LW'(1);
            end
        end
    end

    assign head  = mem[0];
    assign level = count_q;

endmodule

// File: rtl/count_capture.sv
// Captures the upstream counter on each rising edge of an asynchronous event
// and queues {stamp, period since previous event} pairs for a consumer.
module count_capture import count_capture_pkg::*; #(
    parameter int unsigned WIDTH       = CC_WIDTH,
    parameter int unsigned DEPTH       = CC_DEPTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     enable,
    input  logic                     event_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_stamp,
    output logic [WIDTH-1:0]         out_period,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [$clog2(DEPTH):0]   level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   cap;
    cc_state_e              state_q;
    cc_state_e              state_d;
    logic [WIDTH-1:0]       prev_stamp;
    logic [WIDTH-1:0]       period;
    logic                   push;
    logic                   load_prev;
    logic                   pop;
    logic                   drop;
    logic                   full;
    logic                   empty;
    logic [2*WIDTH-1:0]     head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cap = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        load_prev = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = ARM;
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cap) begin
                    state_d   = RUN;
                    load_prev = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cap) begin
                    push      = 1'b1;
                    load_prev = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_stamp <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Updated even when the push is dropped, so periods stay contiguous.
            if (load_prev) prev_stamp <= count_in;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign period    = count_in - prev_stamp;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;

    cc_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({count_in, period}),
        .pop   (pop),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign {out_stamp, out_period} = head;

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_count_capture;
    import count_capture_pkg::*;

    localparam int unsigned W  = 21;
    localparam int unsigned D  = 4;
    localparam int unsigned S  = 2;
    localparam int unsigned LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  count_in;
    logic          enable;
    logic          event_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_stamp;
    logic [W-1:0]  out_period;
    logic          overflow;
    logic          clear_ovf;
    logic [LW-1:0] level;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    count_capture #(
        .WIDTH       (W),
        .DEPTH       (D),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .enable     (enable),
        .event_in   (event_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_stamp  (out_stamp),
        .out_period (out_period),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .level      (level)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: captures land SYNC_STAGES edges after the edge that
    // first samples event_in high; FIFO is a plain queue.
    int          edge_no;
    int          pend[$];
    cc_entry_t   mq[$];
    cc_entry_t   ent;
    logic        ev_prev, en_prev, have_prev, m_ovf, m_cap, m_pop, m_full;
    logic [W-1:0] m_prev;

    always @(posedge clk) begin
        if (!reset) begin
            edge_no = 0;
            pend.delete();
            mq.delete();
            ev_prev = 1'b0; en_prev = 1'b0; have_prev = 1'b0; m_ovf = 1'b0;
            m_prev = '0;
        end else begin
            edge_no++;
            m_cap = 1'b0;
            if (pend.size() > 0 && pend[0] == edge_no) begin
                m_cap = 1'b1;
                void'(pend.pop_front());
            end
            if (event_in && !ev_prev) pend.push_back(edge_no + S);
            ev_prev = event_in;
            m_full  = (mq.size() >= D);
            m_pop   = (mq.size() > 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_cap && enable && en_prev) begin
                if (have_prev) begin
                    ent.stamp  = count_in;
                    ent.period = count_in - m_prev;
                    if (!m_full || m_pop) mq.push_back(ent);
                    else m_ovf = 1'b1;
                end else if (clear_ovf) begin
                    m_ovf = 1'b0;
                end
                have_prev = 1'b1;
                m_prev    = count_in;
            end else if (clear_ovf) begin
                m_ovf = 1'b0;
            end
            if (m_cap && enable && en_prev && have_prev && clear_ovf && (m_full && !m_pop) == 1'b0)
                m_ovf = m_ovf;
            if (!enable) have_prev = 1'b0;
            en_prev = enable;
        end
        #1;
        check("valid", 64'(out_valid), 64'(mq.size() > 0));
        check("level", 64'(level), 64'(mq.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() > 0) begin
            check("stamp", 64'(out_stamp), 64'(mq[0].stamp));
            check("period", 64'(out_period), 64'(mq[0].period));
        end
    end

    task automatic tick();
        @(negedge clk);
        count_in = count_in + W'(1);
    endtask

    task automatic run_to(input logic [W-1:0] x);
        int n = 0;
        while (count_in != x && n < 5000) begin
            tick();
            n++;
        end
        if (n == 5000) begin
            miscompares++;
            $display("FAIL reach: count %0h never reached %0h", count_in, x);
        end
    endtask

    task automatic pulse_at(input logic [W-1:0] x);
        run_to(x);
        event_in = 1'b1;
        tick(); tick();
        event_in = 1'b0;
        tick(); tick();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; event_in = 1'b0;
        out_ready = 1'b0; clear_ovf = 1'b0; count_in = '0;
        repeat (3) tick();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_stamp", 64'(out_stamp), 64'(0));
        check("rst_period", 64'(out_period), 64'(0));
        reset = 1'b1;
        enable = 1'b1;

        // Basic capture: first event arms, stamps land two counts later.
        pulse_at(W'(10));
        check("arm_level", 64'(level), 64'(0));
        pulse_at(W'(110));
        pulse_at(W'(1110));
        check("basic_level", 64'(level), 64'(2));
        check("basic_stamp0", 64'(out_stamp), 64'(112));
        check("basic_period0", 64'(out_period), 64'(100));
        pop_one();
        check("basic_stamp1", 64'(out_stamp), 64'(1112));
        check("basic_period1", 64'(out_period), 64'(1000));
        pop_one();
        check("basic_empty", 64'(out_valid), 64'(0));

        // Wrap-around of the counter.
        count_in = W'(21'h1FFFE0);
        pulse_at(W'(21'h1FFFF0));
        pulse_at(W'(21'h000010));
        pop_one();
        check("wrap_stamp", 64'(out_stamp), 64'(21'h12));
        check("wrap_period", 64'(out_period), 64'(21'h20));
        pop_one();

        // Overflow: six pushes into a four-entry FIFO.
        for (int k = 0; k < 6; k++) pulse_at(W'(100 + 10 * k));
        check("ovf_level", 64'(level), 64'(4));
        check("ovf_flag", 64'(overflow), 64'(1));
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_stamp", 64'(out_stamp), 64'(102 + 10 * k));
            check("ovf_drain_period", 64'(out_period), 64'((k == 0) ? 84 : 10));
            pop_one();
        end
        pulse_at(W'(170));
        check("ovf_next_period", 64'(out_period), 64'(20));
        pop_one();
        check("ovf_sticky", 64'(overflow), 64'(1));
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'(0));

        // Full FIFO with push and pop on the same edge.
        for (int k = 0; k < 4; k++) pulse_at(W'(200 + 10 * k));
        run_to(W'(240));
        event_in = 1'b1;
        tick(); tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        event_in = 1'b0;
        tick();
        check("simul_level", 64'(level), 64'(4));
        check("simul_ovf", 64'(overflow), 64'(0));
        check("simul_head", 64'(out_stamp), 64'(212));

        // Disable and re-arm.
        pop_one(); pop_one();
        enable = 1'b0;
        tick(); tick();
        pulse_at(W'(300));
        check("dis_level", 64'(level), 64'(2));
        enable = 1'b1;
        tick();
        pulse_at(W'(400));
        check("rearm_level", 64'(level), 64'(2));
        check("rearm_head", 64'(out_stamp), 64'(232));
        pulse_at(W'(450));
        check("rearm_level2", 64'(level), 64'(3));
        pop_one(); pop_one();
        check("rearm_stamp", 64'(out_stamp), 64'(452));
        check("rearm_period", 64'(out_period), 64'(50));
        pop_one();

        // Randomized traffic against the model.
        for (int it = 0; it < 250; it++) begin
            int gap;
            gap = int'($urandom_range(2, 10));
            if ($urandom_range(0, 19) == 0) count_in = W'($urandom);
            for (int g = 0; g < gap + 2; g++) begin
                event_in  = (g >= gap);
                out_ready = ($urandom_range(0, 9) < 4);
                clear_ovf = ($urandom_range(0, 15) == 0);
                enable    = ($urandom_range(0, 49) != 0);
                tick();
            end
            event_in = 1'b0;
        end
        clear_ovf = 1'b0;

        // Async reset mid-stream with overflow set and three entries queued.
        enable = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0; enable = 1'b1;
        tick(); tick();
        for (int k = 0; k < 7; k++) pulse_at(count_in + W'(5));
        pop_one();
        check("pre_rst_level", 64'(level), 64'(3));
        check("pre_rst_ovf", 64'(overflow), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_level", 64'(level), 64'(0));
        check("arst_ovf", 64'(overflow), 64'(0));
        check("arst_state", 64'(dut.state_q), 64'(IDLE));
        tick();
        reset = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_capture.md
# count_capture

Time-stamp capture unit that sits directly downstream of the free-running 21-bit counter. It samples the counter value on each rising edge of an asynchronous external event and computes the period since the previous event, modulo 2^WIDTH. It buffers {stamp, period} pairs in a small FIFO and presents them on a valid/ready output port.

## Interface
- WIDTH, 21: width of count_in, stamp and period.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- SYNC_STAGES, 2: synchronizer flops on event_in, ≥2.

- clk  in  1  rising-edge clock, shared with the upstream counter.
- reset  in  1  asynchronous, active-low reset.
- count_in  in  WIDTH  counter value from the upstream counter.
- enable  in  1  synchronous; high = capture active.
- event_in  in  1  asynchronous event; rising edge triggers a capture.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- out_stamp  out  WIDTH  count_in value at the capture.
- out_period  out  WIDTH  out_stamp minus the previous stamp, mod 2^WIDTH.
- overflow  out  1  sticky: a capture was dropped because the FIFO was full.
- clear_ovf  in  1  synchronous clear for overflow.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Event path**
  - event_in passes through a SYNC_STAGES-flop synchronizer, then a 1-flop edge register.
  - A capture pulse fires when the synchronized value is 1 and the edge register holds 0.
- **FSM states**
  - IDLE: enable low. Capture pulses are ignored.
  - ARM: waiting for the first edge.
  - RUN: normal capture.
- **FSM transitions**
  - IDLE→ARM when enable=1.
  - ARM→RUN on a capture pulse. This loads prev_stamp=count_in and pushes nothing.
  - RUN, on each capture pulse: period=count_in−prev_stamp (WIDTH-bit unsigned, wrap by truncation), push {count_in, period}, prev_stamp←count_in.
  - Any state→IDLE when enable=0. prev_stamp becomes don't-care; FIFO contents and overflow are retained.
- **Full FIFO**
  - A capture pulse with level==DEPTH and no pop in the same cycle drops the entry and sets overflow.
  - prev_stamp is still updated, so the next period is measured from the dropped event.
- **Simultaneous events**
  - Pop and push in the same cycle are both performed; when full, no drop occurs and level is unchanged.
  - clear_ovf and a new drop in the same cycle: overflow stays 1 (set wins).
- **Output behaviour**
  - out_stamp and out_period are held stable while out_valid=1 and out_ready=0.
  - Both are don't-care when out_valid=0.
- **Reset values**: state=IDLE, out_valid=0, level=0, overflow=0, synchronizer/edge flops=0, prev_stamp=0. out_stamp and out_period are 0 (registered head).
- **Reset mid-operation**: applied immediately and asynchronously; FIFO contents are discarded.

## Timing
- An event_in rise before clk edge N produces a capture at edge N+SYNC_STAGES (±1 for metastability). count_in is sampled at that edge.
- With the FIFO empty and a pop not pending, out_valid=1 immediately after the capture edge. Latency is SYNC_STAGES+1 edges.
- Throughput is one capture per clock maximum. Events closer than 2 clocks apart may merge; this is permitted.
- A pop at edge M: the next entry, or out_valid=0, appears after edge M.
- level updates on the same edge as the push or pop.

## Structure
- Package count_capture_pkg holds:
  - the FSM state enum (IDLE, ARM, RUN);
  - the entry struct {stamp, period};
  - the default WIDTH and DEPTH localparams.
- Sub-module cc_fifo: a parameterized synchronous FIFO (DEPTH × 2·WIDTH) with registered head, level, full/empty, and same-cycle push/pop.
- Synchronizer, edge detector, FSM and period subtraction live in the top module.

## Test plan
- **Basic capture**: reset, enable=1, count_in incrementing from 0. Pulse event_in at counts 10, 110, 1110.
  - First pulse yields no output.
  - Outputs are {stamp≈110+lat, period=100} then {≈1110+lat, period=1000}.
- **Wrap-around**: events at count_in 0x1FFFF0 and 0x000010 → period=0x20.
- **Overflow**: out_ready=0, 6 events after arming.
  - level=4, overflow=1.
  - Draining yields the first 4 entries.
  - The period of the next event is measured from the 6th event.
  - clear_ovf then clears overflow.
- **Full with simultaneous push and pop**: FIFO full, out_ready=1 on the capture cycle → no drop, level stays 4, overflow=0.
- **Disable and re-arm**: drop enable mid-stream, then re-assert.
  - The first event after re-assert produces no output.
  - The second event's period is measured from the first.
  - The FIFO retains its earlier entries throughout.
- **Async reset mid-stream**: assert reset with level=3 → out_valid, level and overflow go to 0 before the next clk edge; state is IDLE.
